ntt_masked_bfu_result_buffer: RTL and testbench



---
 rtl/ntt_masked_bfu_result_buffer.sv | 137 +++++++++++++
 tb/tb_ntt_masked_bfu_result_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_masked_bfu_result_buffer.sv
// ntt_masked_bfu_result_buffer
// Tracks ops launched into the fixed-latency masked add/sub pipeline with a
// tag delay line. Captures the bit-sliced two-share result as each tag
// emerges and queues it with its write address in a credit-protected FIFO
// that drains over valid/ready. Backpressure is applied at issue through credits
// because the add/sub pipeline cannot stall.
// Optional macro NTT_MASKED_RESBUF_UNMASK_DBG_EN adds the dbg_unmasked output,
// the modular sum of the two head shares, for simulation and debug only.
module ntt_masked_bfu_result_buffer #(
  parameter int WIDTH   = 46,
  parameter int LATENCY = 53,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    zeroize,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic [1:0]              res [WIDTH],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0][WIDTH-1:0]   out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    err_overflow
`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
  ,
  output logic [WIDTH-1:0]        dbg_unmasked
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int CW    = PW + 1;

  logic                  clr;
  logic                  accept;
  logic                  pop;
  logic                  cap_en;
  logic [1:0][WIDTH-1:0] cap_data;

  logic                  tag_vld_p  [LATENCY];
  logic [ADDR_W-1:0]     tag_addr_p [LATENCY];

  logic [1:0][WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0]     mem_addr [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CW-1:0]         credit_cnt;
  logic [CW-1:0]         credit_nxt;

  assign clr    = reset | zeroize;
  assign accept = issue_valid & issue_ready;
  assign pop    = out_valid & out_ready;
  assign cap_en = tag_vld_p[LATENCY-1];

  // ---- stage 0 .. LATENCY-1: tag delay line aligned with the add/sub pipe ----

  // Tag valid bits shift every cycle; cleared so in-flight ops are forgotten.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < LATENCY; k++) tag_vld_p[k] <= 1'b0;
    end else begin
      tag_vld_p[0] <= accept;
      for (int k = 1; k < LATENCY; k++) tag_vld_p[k] <= tag_vld_p[k-1];
    end
  end

  // Tag addresses travel beside their valid bits; meaningless when valid is 0.
  always_ff @(posedge clk) begin
    tag_addr_p[0] <= issue_addr;
    for (int k = 1; k < LATENCY; k++) tag_addr_p[k] <= tag_addr_p[k-1];
  end

  // ---- capture boundary: repack bit-sliced shares into share words ----

  // Each share is gathered bit by bit; the shares themselves are never mixed.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cap_data[0][i] = res[i][0];
      cap_data[1][i] = res[i][1];
    end
  end

  // FIFO storage write; occupancy is bounded by credits so it never overruns.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      mem_data[wr_ptr[PW-1:0]] <= cap_data;
      mem_addr[wr_ptr[PW-1:0]] <= tag_addr_p[LATENCY-1];
    end
  end

  // ---- FIFO head: combinational read at the read pointer ----

  assign out_valid = (wr_ptr != rd_ptr);
  assign out_data  = out_valid ? mem_data[rd_ptr[PW-1:0]] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr[PW-1:0]] : '0;

  // Credit count one cycle ahead: +1 on accept, -1 on pop, unchanged on both.
  always_comb begin
    credit_nxt = credit_cnt;
    case ({accept, pop})
      2'b10:   credit_nxt = credit_cnt + CW'(1);
      2'b01:   credit_nxt = credit_cnt - CW'(1);
      default: credit_nxt = credit_cnt;
    endcase
  end

  // Control state: pointers, credits, registered ready/busy and the sticky error.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      credit_cnt   <= '0;
      issue_ready  <= 1'b0;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      credit_cnt  <= credit_nxt;
      issue_ready <= (credit_nxt < CW'(DEPTH));
      busy        <= (credit_nxt != '0);
      if (issue_valid && !issue_ready) err_overflow <= 1'b1;
      if (cap_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
  // Debug-only recombination of the head shares; never feeds the datapath.
  assign dbg_unmasked = out_data[0] + out_data[1];
`endif

endmodule

// File: tb/tb_ntt_masked_bfu_result_buffer.sv
// Testbench for ntt_masked_bfu_result_buffer: scoreboard of expected results
// pushed at issue and popped as the DUT hands out its FIFO head.
module tb_ntt_masked_bfu_result_buffer;

  localparam int WIDTH   = 46;
  localparam int LATENCY = 53;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 8;

  logic                  clk;
  logic                  reset;
  logic                  zeroize;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_W-1:0]     issue_addr;
  logic [1:0]            res [WIDTH];
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0][WIDTH-1:0] out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic                  busy;
  logic                  err_overflow;
`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
  logic [WIDTH-1:0]      dbg_unmasked;
`endif

  ntt_masked_bfu_result_buffer #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .zeroize(zeroize),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_addr(issue_addr),
    .res(res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .busy(busy),
    .err_overflow(err_overflow)
`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
    ,
    .dbg_unmasked(dbg_unmasked)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  s0;
    logic [WIDTH-1:0]  s1;
    int                due;
  } exp_t;

  exp_t                 sb [$];
  exp_t                 mon_e;
  exp_t                 new_e;
  int                   cyc       = 0;
  int                   n_chk     = 0;
  int                   n_pass    = 0;
  int                   model_cnt = 0;
  bit                   exact_lat = 1'b0;
  int                   ridx;
  int                   n_iss;
  int                   e0;
  logic [2*WIDTH-1:0]   hist [64];
  logic [2*WIDTH-1:0]   pr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*WIDTH-1:0] rnd_pair();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[2*WIDTH-1:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op; its result is presented on res LATENCY edges later.
  task automatic issue_op(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] s0,
                          input logic [WIDTH-1:0] s1);
    issue_valid = 1'b1;
    issue_addr  = a;
    hist[(cyc + 1) % 64] = {s1, s0};
    new_e.addr = a;
    new_e.s0   = s0;
    new_e.s1   = s1;
    new_e.due  = cyc + 1 + LATENCY;
    sb.push_back(new_e);
    model_cnt++;
    tick();
    issue_valid = 1'b0;
  endtask

  // Add/sub model: res for the coming edge is the op issued LATENCY edges earlier.
  always @(posedge clk) begin
    #1;
    ridx = (((cyc + 1 - LATENCY) % 64) + 64) % 64;
    for (int i = 0; i < WIDTH; i++) res[i] = {hist[ridx][WIDTH + i], hist[ridx][i]};
    hist[ridx] = rnd_pair();
  end

  // Scoreboard: every handshake must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!reset && !zeroize && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 128'(out_valid), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        model_cnt--;
        chk("sb_addr", 128'(out_addr), 128'(mon_e.addr));
        chk("sb_share0", 128'(out_data[0]), 128'(mon_e.s0));
        chk("sb_share1", 128'(out_data[1]), 128'(mon_e.s1));
        chk("sb_not_early", 128'(cyc >= mon_e.due), 128'(1));
        if (exact_lat) chk("sb_latency", 128'(cyc), 128'(mon_e.due));
`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
        chk("sb_dbg", 128'(dbg_unmasked), 128'(WIDTH'(mon_e.s0 + mon_e.s1)));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) hist[i] = rnd_pair();
    for (int i = 0; i < WIDTH; i++) res[i] = 2'b00;
    reset = 1'b1; zeroize = 1'b0; issue_valid = 1'b0; issue_addr = '0; out_ready = 1'b0;

    // Test 1: reset
    tick(); tick();
    chk("rst_issue_ready", 128'(issue_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err_overflow), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    reset = 1'b0;
    tick();
    chk("t1_issue_ready", 128'(issue_ready), 128'(1));
    chk("t1_out_valid", 128'(out_valid), 128'(0));
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_err", 128'(err_overflow), 128'(0));

    // Test 2: single op, exact latency
    issue_op(8'h12, 46'h0000_0000_1234, 46'h0000_0000_0001);
    repeat (LATENCY - 1) tick();
    chk("t2_not_yet_valid", 128'(out_valid), 128'(0));
    tick();
    chk("t2_out_valid", 128'(out_valid), 128'(1));
    chk("t2_share0", 128'(out_data[0]), 128'(46'h1234));
    chk("t2_share1", 128'(out_data[1]), 128'(46'h1));
    chk("t2_addr", 128'(out_addr), 128'(8'h12));
    chk("t2_busy", 128'(busy), 128'(1));
`ifdef NTT_MASKED_RESBUF_UNMASK_DBG_EN
    chk("t2_dbg", 128'(dbg_unmasked), 128'(46'h1235));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_drained_valid", 128'(out_valid), 128'(0));
    chk("t2_drained_busy", 128'(busy), 128'(0));

    // Test 4: streaming under credit control, consumer always ready
    exact_lat = 1'b1;
    out_ready = 1'b1;
    n_iss = 0;
    for (int c = 0; c < 3000 && n_iss < 100; c++) begin
      chk("t4_ready_vs_credit", 128'(issue_ready), 128'(model_cnt < DEPTH));
      if (model_cnt < DEPTH) begin
        pr = rnd_pair();
        issue_op(ADDR_W'(n_iss), pr[WIDTH-1:0], pr[2*WIDTH-1:WIDTH]);
        n_iss++;
      end else begin
        tick();
      end
    end
    chk("t4_all_issued", 128'(n_iss), 128'(100));
    repeat (LATENCY + 4) tick();
    chk("t4_sb_empty", 128'(sb.size()), 128'(0));
    chk("t4_err", 128'(err_overflow), 128'(0));
    chk("t4_busy", 128'(busy), 128'(0));
    exact_lat = 1'b0;
    out_ready = 1'b0;

    // Test 3: credit limit with consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      pr = rnd_pair();
      issue_op(ADDR_W'(i), pr[WIDTH-1:0], pr[2*WIDTH-1:WIDTH]);
      if (i == DEPTH - 2) chk("t3_ready_before_last", 128'(issue_ready), 128'(1));
    end
    chk("t3_ready_exhausted", 128'(issue_ready), 128'(0));
    repeat (LATENCY) tick();
    chk("t3_full_valid", 128'(out_valid), 128'(1));
    chk("t3_full_head_addr", 128'(out_addr), 128'(0));
    chk("t3_full_busy", 128'(busy), 128'(1));

    // Test 5: issue while not ready
    issue_valid = 1'b1;
    issue_addr  = 8'hEE;
    tick();
    issue_valid = 1'b0;
    chk("t5_err_set", 128'(err_overflow), 128'(1));
    chk("t5_ready", 128'(issue_ready), 128'(0));
    chk("t5_head_addr", 128'(out_addr), 128'(0));
    repeat (3) tick();
    chk("t5_err_sticky", 128'(err_overflow), 128'(1));

    // Pop one entry: a credit returns
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ready_back", 128'(issue_ready), 128'(1));
    chk("t3_next_head", 128'(out_addr), 128'(1));
    out_ready = 1'b1;
    repeat (LATENCY + 10) tick();
    out_ready = 1'b0;
    chk("t5_no_extra_entry", 128'(sb.size()), 128'(0));
    chk("t5_valid_after_drain", 128'(out_valid), 128'(0));
    chk("t5_busy_after_drain", 128'(busy), 128'(0));
    chk("t5_err_still_set", 128'(err_overflow), 128'(1));

    // Test 6: zeroize with ops in flight
    e0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      pr = rnd_pair() | 92'h1;
      issue_op(ADDR_W'(8'h40 + i), pr[WIDTH-1:0], pr[2*WIDTH-1:WIDTH]);
    end
    while (cyc < e0 + 19) tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    sb.delete();
    model_cnt = 0;
    chk("t6_ready", 128'(issue_ready), 128'(0));
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_err_cleared", 128'(err_overflow), 128'(0));
    chk("t6_out_data", 128'(out_data), 128'(0));
    chk("t6_out_addr", 128'(out_addr), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("t6_ready_after", 128'(issue_ready), 128'(1));
    while (cyc < e0 + 61) begin
      tick();
      chk("t6_no_late_valid", 128'(out_valid), 128'(0));
    end
    chk("end_sb_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
